// File: rtl/systolic_feed_ctrl_pkg.sv
// rtl/systolic_feed_ctrl_pkg.sv - shared array config (ARRAYWIDTH/DATASIZE), feed states, phase counter widths
`ifndef ARRAYWIDTH
`define ARRAYWIDTH 4
`endif
`ifndef DATASIZE
`define DATASIZE 16
`endif

package systolic_feed_ctrl_pkg;

  localparam int ARRAY_W     = `ARRAYWIDTH;
  localparam int PHASE_CNT_W = $clog2(2 * ARRAY_W);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_FEED   = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_RESULT = 3'd5
  } feed_state_t;

  // Phase lengths are loaded as length-1 so the zero flag marks the last cycle.
  localparam logic [PHASE_CNT_W-1:0] LOAD_LEN_M1  = PHASE_CNT_W'(ARRAY_W - 1);
  localparam logic [PHASE_CNT_W-1:0] FEED_LEN_M1  = PHASE_CNT_W'(2 * ARRAY_W - 2);
  localparam logic [PHASE_CNT_W-1:0] DRAIN_LEN_M1 = PHASE_CNT_W'(ARRAY_W - 1);

endpackage

// File: rtl/feed_phase_cnt.sv
// rtl/feed_phase_cnt.sv - loadable down-counter with enable and zero flag for feed phase lengths
module feed_phase_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - tile feed sequencer for the systolic array row shifters
// Optional FEED_CTRL_PERF_EN adds the perf_stall LOAD-stall counter output.
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [TILE_W-1:0] tile_count,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              src_valid,
  input  logic              abort,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd,
  output logic              load_en,
  output logic              out_en,
  output logic              acc_clr,
  output logic              result_valid,
  output logic              busy,
`ifdef FEED_CTRL_PERF_EN
  output logic [31:0]       perf_stall,
`endif
  output logic              done
);

  feed_state_t             state;
  feed_state_t             nxt;
  logic                    done_nxt;
  logic                    start_acc;
  logic [TILE_W-1:0]       tiles_left;
  logic                    cnt_load;
  logic                    cnt_en;
  logic                    cnt_zero;
  logic [PHASE_CNT_W-1:0]  cnt_val;
  logic [PHASE_CNT_W-1:0]  cnt;

  assign start_acc = (state == ST_IDLE) && start && (tile_count != '0);
  // Loading depends on the live src_valid, so this strobe cannot be registered.
  assign load_en   = (state == ST_LOAD) && src_valid;

  always_comb begin
    nxt      = state;
    done_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (tile_count != '0) nxt = ST_CLR;
          else                  done_nxt = 1'b1;
        end
      end
      ST_CLR:    nxt = ST_LOAD;
      ST_LOAD:   if (src_valid && cnt_zero) nxt = ST_FEED;
      ST_FEED:   if (cnt_zero) nxt = ST_DRAIN;
      ST_DRAIN:  if (cnt_zero) nxt = ST_RESULT;
      ST_RESULT: nxt = (tiles_left > TILE_W'(1)) ? ST_CLR : ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
    if (abort && (state != ST_IDLE)) nxt = ST_IDLE;
    if ((nxt == ST_RESULT) && (tiles_left == TILE_W'(1))) done_nxt = 1'b1;
  end

  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = DRAIN_LEN_M1;
    case (state)
      ST_CLR: begin
        cnt_load = 1'b1;
        cnt_val  = LOAD_LEN_M1;
      end
      ST_LOAD: begin
        cnt_load = src_valid && cnt_zero;
        cnt_val  = FEED_LEN_M1;
      end
      ST_FEED: begin
        cnt_load = cnt_zero;
        cnt_val  = DRAIN_LEN_M1;
      end
      default: begin
        cnt_load = 1'b0;
        cnt_val  = DRAIN_LEN_M1;
      end
    endcase
  end

  assign cnt_en = load_en || (state == ST_FEED) || (state == ST_DRAIN);

  feed_phase_cnt #(
    .CNT_W (PHASE_CNT_W)
  ) u_phase_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .en       (cnt_en),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      tiles_left   <= '0;
      src_addr     <= '0;
      src_rd       <= 1'b0;
      out_en       <= 1'b0;
      acc_clr      <= 1'b0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= nxt;
      src_rd       <= (nxt == ST_LOAD);
      out_en       <= (nxt == ST_FEED);
      acc_clr      <= (nxt == ST_CLR);
      result_valid <= (nxt == ST_RESULT);
      busy         <= (nxt != ST_IDLE);
      done         <= done_nxt;
      if (start_acc) begin
        tiles_left <= tile_count;
        src_addr   <= base_addr;
      end else begin
        if (load_en) src_addr <= src_addr + ADDR_W'(1);
        if (state == ST_RESULT) tiles_left <= tiles_left - TILE_W'(1);
      end
    end
  end

`ifdef FEED_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall <= '0;
    end else if (start_acc) begin
      perf_stall <= '0;
    end else if ((state == ST_LOAD) && !src_valid && (perf_stall != '1)) begin
      perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

  logic unused_cnt;
  assign unused_cnt = ^cnt;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - directed self-checking bench for systolic_feed_ctrl at ARRAYWIDTH=4
module tb_systolic_feed_ctrl;
  import systolic_feed_ctrl_pkg::*;

  localparam int AW = 16;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [TW-1:0] tile_count = '0;
  logic [AW-1:0] base_addr = '0;
  logic          src_valid = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_addr;
  logic          src_rd, load_en, out_en, acc_clr, result_valid, busy, done;
`ifdef FEED_CTRL_PERF_EN
  logic [31:0]   perf_stall;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  systolic_feed_ctrl #(.ADDR_W(AW), .TILE_W(TW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .tile_count   (tile_count),
    .base_addr    (base_addr),
    .src_valid    (src_valid),
    .abort        (abort),
    .src_addr     (src_addr),
    .src_rd       (src_rd),
    .load_en      (load_en),
    .out_en       (out_en),
    .acc_clr      (acc_clr),
    .result_valid (result_valid),
    .busy         (busy),
`ifdef FEED_CTRL_PERF_EN
    .perf_stall   (perf_stall),
`endif
    .done         (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // {src_rd, load_en, out_en, acc_clr, result_valid, busy, done}
  function automatic logic [6:0] outs();
    return {src_rd, load_en, out_en, acc_clr, result_valid, busy, done};
  endfunction

  // Enter a new cycle: inputs change after the edge, sampling happens 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // W=4 tile: CLR at offset 0, LOAD 1-4, FEED 5-11, DRAIN 12-15, RESULT 16 (17 cycles).
  task automatic run_job(input string name, input logic [AW-1:0] base, input int tiles, input bit poke_start);
    logic [6:0]    exp;
    logic [AW-1:0] exp_addr;
    int            o, k;
    start = 1'b1; tile_count = TW'(tiles); base_addr = base; src_valid = 1'b1;
    for (int c = 1; c <= 17 * tiles + 1; c++) begin
      step();
      start = 1'b0;
      if (poke_start && c == 3) begin
        start = 1'b1; tile_count = 8'd9; base_addr = 16'h0BAD;
      end
      #1;
      o = (c - 1) % 17;
      k = (c - 1) / 17;
      if (c > 17 * tiles) begin
        exp = 7'b0;
      end else begin
        exp = {(o >= 1 && o <= 4), (o >= 1 && o <= 4), (o >= 5 && o <= 11),
               (o == 0), (o == 16), 1'b1, (c == 17 * tiles)};
      end
      check_eq($sformatf("%s outs c%0d", name, c), 32'(outs()), 32'(exp));
      if (o >= 1 && o <= 4 && c <= 17 * tiles) begin
        exp_addr = base + AW'(k * 4 + o - 1);
        check_eq($sformatf("%s addr c%0d", name, c), 32'(src_addr), 32'(exp_addr));
      end
    end
  endtask

  initial begin
    int n_load, first_out, rv_cycle;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset outs", 32'(outs()), 32'h0);
    check_eq("reset addr", 32'(src_addr), 32'h0);
    rst = 1'b1;
    #1;

    run_job("single", 16'h0010, 1, 1'b0);
    run_job("three", 16'h0010, 3, 1'b0);

    // Two-cycle source stall mid-LOAD
    start = 1'b1; tile_count = 8'd1; base_addr = 16'h0040; src_valid = 1'b1;
    n_load = 0; first_out = 0; rv_cycle = 0;
    for (int c = 1; c <= 20; c++) begin
      step();
      start = 1'b0;
      src_valid = !(c == 4 || c == 5);
      #1;
      if (load_en) n_load++;
      if (load_en && out_en) check_eq("stall overlap", 32'(c), 32'h0);
      if (out_en && first_out == 0) first_out = c;
      if (result_valid) rv_cycle = c;
    end
    src_valid = 1'b1;
    check_eq("stall load count", 32'(n_load), 32'd4);
    check_eq("stall first feed", 32'(first_out), 32'd8);
    check_eq("stall result cycle", 32'(rv_cycle), 32'd19);
    check_eq("stall end addr", 32'(src_addr), 32'h0044);
`ifdef FEED_CTRL_PERF_EN
    check_eq("perf stall", perf_stall, 32'd2);
`endif

    // Abort during FEED
    start = 1'b1; tile_count = 8'd2; base_addr = 16'h0050;
    for (int c = 1; c <= 7; c++) begin
      step();
      start = 1'b0;
      #1;
    end
    check_eq("abort pre feed", 32'(out_en), 32'h1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    check_eq("abort idle", 32'(outs()), 32'h0);
    for (int c = 0; c < 20; c++) begin
      step();
      #1;
      if (outs() != 7'b0) check_eq($sformatf("abort quiet c%0d", c), 32'(outs()), 32'h0);
    end
    check_eq("abort quiet end", 32'(outs()), 32'h0);
    run_job("after abort", 16'h0020, 1, 1'b0);

    // Asynchronous reset during DRAIN
    start = 1'b1; tile_count = 8'd1; base_addr = 16'h0060;
    for (int c = 1; c <= 14; c++) begin
      step();
      start = 1'b0;
      #1;
    end
    check_eq("drain outs", 32'(outs()), 32'h02);
    rst = 1'b0;
    #1;
    check_eq("rst async outs", 32'(outs()), 32'h0);
    check_eq("rst async addr", 32'(src_addr), 32'h0);
    step();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      check_eq($sformatf("post rst idle c%0d", c), 32'(outs()), 32'h0);
    end

    // Zero-tile start
    start = 1'b1; tile_count = 8'd0; base_addr = 16'h0070;
    step();
    start = 1'b0;
    #1;
    check_eq("zero done", 32'(outs()), 32'h01);
    step();
    #1;
    check_eq("zero done clr", 32'(outs()), 32'h0);

    // Address wrap, with a start pulse while busy that must be ignored
    run_job("wrap", 16'hFFFE, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
